// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC transmit path.
//   - framer state encoding
//   - preamble/SFD byte values
//   - CRC-32 (reflected Ethernet polynomial) constants and check residue
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } mac_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

endpackage

// File: rtl/mac_tx_framer_if.sv
// mac_tx_framer_if: user-side byte stream plus PHY-side byte stream of the
// transmit framer.
//   mac_valid/mac_last/mac_data : user byte, last-byte marker
//   mac_ready                   : byte accepted on mac_valid & mac_ready
//   phy_valid/phy_error/phy_data: PHY TX byte stream
//   busy                        : framer not idle
// master = packet source / PHY observer, slave = framer.
interface mac_tx_framer_if;
  logic       mac_valid;
  logic       mac_last;
  logic [7:0] mac_data;
  logic       mac_ready;
  logic       phy_valid;
  logic       phy_error;
  logic [7:0] phy_data;
  logic       busy;

  modport master (
    output mac_valid, mac_last, mac_data,
    input  mac_ready, phy_valid, phy_error, phy_data, busy
  );

  modport slave (
    input  mac_valid, mac_last, mac_data,
    output mac_ready, phy_valid, phy_error, phy_data, busy
  );
endinterface

// File: rtl/mac_tx_framer_crc32.sv
// crc32: one-byte step of the reflected Ethernet CRC-32 (LSB of the byte
// first). Purely combinational.
//   data_in   : byte to fold in
//   state_in  : current CRC register
//   state_out : CRC register after the byte
module crc32
  import mac_pkg::*;
(
  input  logic [7:0]  data_in,
  input  logic [31:0] state_in,
  output logic [31:0] state_out
);

  logic [31:0] c_v;

  always_comb begin
    c_v = state_in;
    for (int i = 0; i < 8; i++) begin
      if (c_v[0] ^ data_in[i]) c_v = (c_v >> 1) ^ CRC_POLY_REFL;
      else                     c_v = c_v >> 1;
    end
    state_out = c_v;
  end

endmodule

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: Ethernet MAC transmit framer. Wraps a user byte stream with
// preamble + SFD, optional minimum-length zero padding and FCS, then holds the
// line idle for the inter-frame gap.
//   phy_clk   : single clock
//   phy_rst_n : asynchronous active-low reset
//   bus       : mac_tx_framer_if.slave (user stream in, PHY stream out, busy)
// Build option: MAC_TX_PAD_EN - when defined, frames shorter than MIN_PAYLOAD
// are zero-padded before the FCS; otherwise the PAD state is absent.
//
// state    | meaning
// IDLE     | waiting for mac_valid, nothing on the PHY
// PREAMBLE | sending PREAMBLE_LEN x 0x55 then the SFD
// DATA     | forwarding user bytes, folding them into the CRC
// PAD      | sending 0x00 up to MIN_PAYLOAD (pad build only)
// FCS      | sending ~crc, least significant byte first
// IFG      | IFG_LEN idle cycles, user input ignored
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
`ifdef MAC_TX_PAD_EN
  parameter int MIN_PAYLOAD  = 60,
`endif
  parameter int MAX_PAYLOAD  = 1514,
  parameter int IFG_LEN      = 12
) (
  input  logic            phy_clk,
  input  logic            phy_rst_n,
  mac_tx_framer_if.slave  bus
);

  localparam logic [10:0] PRE_CNT = 11'(PREAMBLE_LEN);
  localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IFG_CNT = 11'(IFG_LEN - 1);
`ifdef MAC_TX_PAD_EN
  localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
`endif

  mac_state_e  st_q, st_d;
  // Shared counter: preamble bytes, payload length, FCS byte index, IFG countdown.
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        pv_q, pv_d;
  logic        pe_q, pe_d;
  logic [7:0]  pd_q, pd_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic [7:0]  crc_byte;
  logic [31:0] crc_next;
  logic [31:0] crc_inv;

  // Pad bytes are zeros, so the CRC input only needs the user byte in DATA.
  assign crc_byte = (st_q == ST_DATA) ? bus.mac_data : 8'h00;
  assign crc_inv  = ~crc_q;

  crc32 u_crc32 (
    .data_in   (crc_byte),
    .state_in  (crc_q),
    .state_out (crc_next)
  );

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    crc_d = crc_q;
    pv_d  = 1'b0;
    pe_d  = 1'b0;
    pd_d  = 8'h00;
    case (st_q)
      ST_IDLE: begin
        if (bus.mac_valid) begin
          st_d  = ST_PREAMBLE;
          pv_d  = 1'b1;
          pd_d  = PREAMBLE_BYTE;
          cnt_d = 11'd1;
        end
      end
      ST_PREAMBLE: begin
        pv_d = 1'b1;
        if (cnt_q == PRE_CNT) begin
          pd_d  = SFD_BYTE;
          st_d  = ST_DATA;
          cnt_d = 11'd0;
          crc_d = CRC_INIT;
        end else begin
          pd_d  = PREAMBLE_BYTE;
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_DATA: begin
        pv_d = 1'b1;
        // rdy_q is low once MAX_PAYLOAD bytes are in, so oversize and
        // underrun both land in the abort branch.
        if (rdy_q && bus.mac_valid) begin
          pd_d  = bus.mac_data;
          crc_d = crc_next;
          cnt_d = cnt_q + 11'd1;
          if (bus.mac_last) begin
`ifdef MAC_TX_PAD_EN
            if (cnt_q + 11'd1 < MIN_CNT) begin
              st_d = ST_PAD;
            end else begin
              st_d  = ST_FCS;
              cnt_d = 11'd0;
            end
`else
            st_d  = ST_FCS;
            cnt_d = 11'd0;
`endif
          end
        end else begin
          pe_d  = 1'b1;
          st_d  = ST_IFG;
          cnt_d = IFG_CNT;
        end
      end
`ifdef MAC_TX_PAD_EN
      ST_PAD: begin
        pv_d  = 1'b1;
        crc_d = crc_next;
        cnt_d = cnt_q + 11'd1;
        if (cnt_q + 11'd1 == MIN_CNT) begin
          st_d  = ST_FCS;
          cnt_d = 11'd0;
        end
      end
`endif
      ST_FCS: begin
        pv_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    pd_d = crc_inv[7:0];
          2'd1:    pd_d = crc_inv[15:8];
          2'd2:    pd_d = crc_inv[23:16];
          default: pd_d = crc_inv[31:24];
        endcase
        if (cnt_q[1:0] == 2'd3) begin
          st_d  = ST_IFG;
          cnt_d = IFG_CNT;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_IFG: begin
        if (cnt_q == 11'd0) st_d = ST_IDLE;
        else                cnt_d = cnt_q - 11'd1;
      end
      default: st_d = ST_IDLE;
    endcase
    rdy_d  = (st_d == ST_DATA) && (cnt_d != MAX_CNT);
    busy_d = (st_d != ST_IDLE);
  end

  always_ff @(posedge phy_clk or negedge phy_rst_n) begin
    if (!phy_rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= 11'd0;
      crc_q  <= CRC_INIT;
      pv_q   <= 1'b0;
      pe_q   <= 1'b0;
      pd_q   <= 8'h00;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      crc_q  <= crc_d;
      pv_q   <= pv_d;
      pe_q   <= pe_d;
      pd_q   <= pd_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

  assign bus.mac_ready = rdy_q;
  assign bus.phy_valid = pv_q;
  assign bus.phy_error = pe_q;
  assign bus.phy_data  = pd_q;
  assign bus.busy      = busy_q;

endmodule
